sensor_debounce_pair: RTL

- Two-channel synchroniser and debouncer for the parking-meter vehicle sensors `a` and `b`.
- Sits directly upstream of the entry/exit counting FSM. Cleans raw photo-sensor/pushbutton levels into stable levels plus single-cycle edge pulses.
- A shared free-running tick counter paces both channels. Each channel has its own 4-state debounce FSM with a confirm counter.

---
 rtl/sensor_debounce_pair.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sensor_debounce_pair.sv
// Purpose: two-channel synchroniser + debouncer turning raw sensor levels into clean levels and edge pulses.
// Latency: 2 sync clocks, then acceptance on the CONFIRM-th shared tick after a level change is first seen.
// Backpressure: none; outputs are free-running registered levels and one-cycle pulses.

// One debounce channel: 2-flop synchroniser, 4-state confirm FSM, registered level and pulses.
module sensor_debounce_chan #(
  parameter int CONFIRM = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic lvl,
  output logic rise,
  output logic fall
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  // Confirm counter reload: CONFIRM-1 more ticks after the first one in WAIT.
  localparam logic [3:0] CNT_INIT = 4'(CONFIRM - 1);

  logic   sync1_q, sync1_d;
  logic   sync2_q, sync2_d;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic   lvl_q, lvl_d;
  logic   rise_q, rise_d;
  logic   fall_q, fall_d;
  logic   s;

  assign s = sync2_q;

  // Next-state logic: synchroniser shift, confirm FSM, level and pulse generation.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ZERO: begin
        if (s) begin
          state_d = WAIT1;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT1: begin
        if (!s) begin
          state_d = ZERO;
        end else if (tick && cnt_q == 4'd0) begin
          state_d = ONE;
          rise_d  = 1'b1;
        end else if (tick) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ONE: begin
        if (!s) begin
          state_d = WAIT0;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT0: begin
        if (s) begin
          state_d = ONE;
        end else if (tick && cnt_q == 4'd0) begin
          state_d = ZERO;
          fall_d  = 1'b1;
        end else if (tick) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ZERO;
      end
    endcase
    // Level follows the accepted state, so it moves in the same cycle as the pulse.
    lvl_d = (state_d == ONE) || (state_d == WAIT0);
  end

  // State registers; reset drops any pending confirmation without emitting a pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ZERO;
      cnt_q   <= 4'd0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign lvl  = lvl_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// Top: shared tick counter pacing two independent debounce channels.
module sensor_debounce_pair #(
  parameter int TICK_BITS = 19,
  parameter int CONFIRM   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  localparam logic [TICK_BITS-1:0] TICK_ONE = TICK_BITS'(1);

  logic [TICK_BITS-1:0] tick_cnt_q, tick_cnt_d;
  logic                 tick;

  // Free-running tick counter; wraps naturally from all-ones to zero.
  always_comb begin
    tick_cnt_d = tick_cnt_q + TICK_ONE;
  end

  // Tick counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Tick is the single cycle the counter sits at all-ones.
  assign tick = &tick_cnt_q;

  sensor_debounce_chan #(.CONFIRM(CONFIRM)) u_chan_a (
    .clk   (clk),
    .reset (reset),
    .raw   (a_raw),
    .tick  (tick),
    .lvl   (a),
    .rise  (a_rise),
    .fall  (a_fall)
  );

  sensor_debounce_chan #(.CONFIRM(CONFIRM)) u_chan_b (
    .clk   (clk),
    .reset (reset),
    .raw   (b_raw),
    .tick  (tick),
    .lvl   (b),
    .rise  (b_rise),
    .fall  (b_fall)
  );

endmodule
